fp_align_pipe: RTL and testbench

//  Parametrised, pipelined N-input floating-point mantissa aligner for the FC accumulation path.

---
 rtl/fp_align_if.sv | 28 ++
 rtl/fp_align_pipe.sv | 137 +++++++++++++
 tb/tb_fp_align_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_if.sv
// Operand/result bundle for the floating-point mantissa aligner.
// The master side supplies operand sets and takes aligned results; the slave side is the aligner.
interface fp_align_if #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int NUM_IN   = 4,
  parameter int GUARD    = 2
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [NUM_IN*(EXPONENT+MANTISSA+1)-1:0]   in_data;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [NUM_IN*(MANTISSA+GUARD+2)-1:0]      out_mant;
  logic [NUM_IN-1:0]                         out_sign;
  logic [EXPONENT-1:0]                       out_max_exp;
  logic                                      out_all_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mant, out_sign, out_max_exp, out_all_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mant, out_sign, out_max_exp, out_all_zero
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage pipelined N-input mantissa aligner.
// Stage 1 registers the unpacked operands and their maximum exponent (balanced compare tree);
// stage 2 right-shifts every restored mantissa to that exponent, keeping guard bits and a sticky bit.
module fp_align_pipe #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int NUM_IN   = 4,
  parameter int GUARD    = 2
) (
  input logic       clk,
  input logic       rst_n,
  fp_align_if.slave bus
);
  localparam int DW     = EXPONENT + MANTISSA + 1;
  localparam int MW     = MANTISSA + GUARD + 2;
  localparam int PW     = MW - 1;
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int P      = 1 << LEVELS;

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s1_adv;
  logic                     s2_adv;

  logic [EXPONENT-1:0]      in_exp   [NUM_IN];
  logic [MANTISSA-1:0]      in_mant  [NUM_IN];
  logic [NUM_IN-1:0]        in_sign;
  logic [EXPONENT-1:0]      in_max_exp;

  logic [EXPONENT-1:0]      s1_exp   [NUM_IN];
  logic [MANTISSA-1:0]      s1_mant  [NUM_IN];
  logic [NUM_IN-1:0]        s1_hid;
  logic [NUM_IN-1:0]        s1_sign;
  logic [EXPONENT-1:0]      s1_max_exp;

  logic [NUM_IN*MW-1:0]     mant_nxt;
  logic [NUM_IN*MW-1:0]     out_mant_q;
  logic [NUM_IN-1:0]        out_sign_q;
  logic [EXPONENT-1:0]      out_max_q;
  logic                     out_zero_q;

  // Flow control: a stage may advance when it is empty or the stage after it advances.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid    = s2_valid;
  assign bus.out_mant     = out_mant_q;
  assign bus.out_sign     = out_sign_q;
  assign bus.out_max_exp  = out_max_q;
  assign bus.out_all_zero = out_zero_q;

  // Unpack every operand into sign, exponent and stored mantissa.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign in_exp[i]  = bus.in_data[i*DW+MANTISSA +: EXPONENT];
    assign in_mant[i] = bus.in_data[i*DW +: MANTISSA];
    assign in_sign[i] = bus.in_data[i*DW+DW-1];
  end

  // Balanced max tree; unused leaves are padded with exponent 0, which never wins.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [EXPONENT-1:0] v [P>>l];
    for (genvar k = 0; k < (P >> l); k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < NUM_IN) begin : g_op
          assign v[k] = in_exp[k];
        end else begin : g_pad
          assign v[k] = '0;
        end
      end else begin : g_cmp
        assign v[k] = (g_lvl[l-1].v[2*k] >= g_lvl[l-1].v[2*k+1]) ?
                      g_lvl[l-1].v[2*k] : g_lvl[l-1].v[2*k+1];
      end
    end
  end

  assign in_max_exp = g_lvl[LEVELS].v[0];

  // Stage 1 register: operands with zero exponent are flushed (hidden bit and mantissa cleared).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_max_exp <= '0;
      s1_hid     <= '0;
      s1_sign    <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        s1_exp[i]  <= '0;
        s1_mant[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_max_exp <= in_max_exp;
        s1_sign    <= in_sign;
        for (int i = 0; i < NUM_IN; i++) begin
          s1_exp[i]  <= in_exp[i];
          s1_hid[i]  <= |in_exp[i];
          s1_mant[i] <= (|in_exp[i]) ? in_mant[i] : '0;
        end
      end
    end
  end

  // Per-operand alignment shift; shifts past the pre-shift width collapse into the sticky bit.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_shift
    logic [EXPONENT-1:0] shift;
    logic [PW-1:0]       pre;
    logic [PW-1:0]       mask;
    logic                sat;

    assign shift = s1_max_exp - s1_exp[i];
    assign pre   = {s1_hid[i], s1_mant[i], {GUARD{1'b0}}};
    assign sat   = 32'(shift) >= 32'(PW);
    assign mask  = ~({PW{1'b1}} << shift);
    assign mant_nxt[i*MW +: MW] = sat ? {{PW{1'b0}}, |pre}
                                      : {pre >> shift, |(pre & mask)};
  end

  // Stage 2 / output register: holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_mant_q <= '0;
      out_sign_q <= '0;
      out_max_q  <= '0;
      out_zero_q <= 1'b1;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant_q <= mant_nxt;
        out_sign_q <= s1_sign;
        out_max_q  <= s1_max_exp;
        out_zero_q <= (s1_max_exp == '0);
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed testbench for fp_align_pipe: hand-computed vectors for alignment, saturation,
// zero flush, streaming, backpressure and asynchronous reset.
module tb_fp_align_pipe;
  localparam int EXPONENT = 8;
  localparam int MANTISSA = 23;
  localparam int NUM_IN   = 4;
  localparam int GUARD    = 2;
  localparam int DW       = EXPONENT + MANTISSA + 1;
  localparam int MW       = MANTISSA + GUARD + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  fp_align_if #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA), .NUM_IN(NUM_IN), .GUARD(GUARD)) bus ();

  fp_align_pipe #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA), .NUM_IN(NUM_IN), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] op(input logic s, input logic [7:0] e, input logic [22:0] m);
    return {s, e, m};
  endfunction

  // Set j: all operands share exponent 100+j, mantissa j*16+i, sign bit i = bit i of j.
  function automatic logic [NUM_IN*DW-1:0] same_set(input int j);
    logic [NUM_IN*DW-1:0] r;
    logic [31:0]          jj;
    r  = '0;
    jj = j;
    for (int i = 0; i < NUM_IN; i++)
      r[i*DW +: DW] = op(jj[i], 8'(100 + j), 23'(j*16 + i));
    return r;
  endfunction

  // Equal exponents mean zero shift: {1, mant, 00, sticky 0} = 2^26 | mant*8.
  function automatic logic [NUM_IN*MW-1:0] same_mant(input int j);
    logic [NUM_IN*MW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IN; i++)
      r[i*MW +: MW] = 27'h4000000 | 27'((j*16 + i) * 8);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [NUM_IN*DW-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0);
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_mant !== '0) begin fails++; $display("[TB] FAIL reset_mant got %h expected 0", bus.out_mant); end
    checks++; if (bus.out_sign !== 4'h0) begin fails++; $display("[TB] FAIL reset_sign got %h expected 0", bus.out_sign); end
    checks++; if (bus.out_max_exp !== 8'h00) begin fails++; $display("[TB] FAIL reset_max got %h expected 0", bus.out_max_exp); end
    checks++; if (bus.out_all_zero !== 1'b1) begin fails++; $display("[TB] FAIL reset_zero got %b expected 1", bus.out_all_zero); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_powers();
    @(negedge clk);
    drive(1'b1, {op(0, 8'd130, 0), op(0, 8'd129, 0), op(0, 8'd128, 0), op(0, 8'd127, 0)});
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL t1_ready got %b expected 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b0, '0);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t1_lat1 got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t1_lat2 got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_mant !== {27'h4000000, 27'h2000000, 27'h1000000, 27'h0800000})
      begin fails++; $display("[TB] FAIL t1_mant got %h", bus.out_mant); end
    checks++; if (bus.out_max_exp !== 8'd130) begin fails++; $display("[TB] FAIL t1_max got %0d expected 130", bus.out_max_exp); end
    checks++; if (bus.out_all_zero !== 1'b0) begin fails++; $display("[TB] FAIL t1_zero got %b expected 0", bus.out_all_zero); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t1_drain got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    drive(1'b1, {op(0, 8'd105, 0), op(1, 8'd126, 23'h1), op(0, 8'd100, 23'h7FFFFF), op(1, 8'd130, 0)});
    @(negedge clk);
    drive(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t2_valid got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_mant !== {27'h0000002, 27'h0400001, 27'h0000001, 27'h4000000})
      begin fails++; $display("[TB] FAIL t2_mant got %h", bus.out_mant); end
    checks++; if (bus.out_max_exp !== 8'd130) begin fails++; $display("[TB] FAIL t2_max got %0d expected 130", bus.out_max_exp); end
    checks++; if (bus.out_sign !== 4'b0101) begin fails++; $display("[TB] FAIL t2_sign got %b expected 0101", bus.out_sign); end
  endtask

  task automatic test_all_zero();
    @(negedge clk);
    drive(1'b1, {op(0, 0, 23'h123), op(0, 0, 23'h400000), op(1, 0, 23'h1), op(1, 0, 23'h7FFFFF)});
    @(negedge clk);
    drive(1'b0, '0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t3_valid got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_mant !== '0) begin fails++; $display("[TB] FAIL t3_mant got %h expected 0", bus.out_mant); end
    checks++; if (bus.out_max_exp !== 8'd0) begin fails++; $display("[TB] FAIL t3_max got %0d expected 0", bus.out_max_exp); end
    checks++; if (bus.out_all_zero !== 1'b1) begin fails++; $display("[TB] FAIL t3_zero got %b expected 1", bus.out_all_zero); end
    checks++; if (bus.out_sign !== 4'b0011) begin fails++; $display("[TB] FAIL t3_sign got %b expected 0011", bus.out_sign); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) drive(1'b1, same_set(k)); else drive(1'b0, '0);
      #1;
      if (k < 8) begin
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL t4_ready k=%0d got %b expected 1", k, bus.in_ready); end
      end
      checks++; if (bus.out_valid !== (k >= 2)) begin fails++; $display("[TB] FAIL t4_valid k=%0d got %b expected %b", k, bus.out_valid, k >= 2); end
      if (k >= 2) begin
        checks++; if (bus.out_mant !== same_mant(k-2)) begin fails++; $display("[TB] FAIL t4_mant k=%0d got %h expected %h", k, bus.out_mant, same_mant(k-2)); end
        checks++; if (bus.out_max_exp !== 8'(100 + k - 2)) begin fails++; $display("[TB] FAIL t4_max k=%0d got %0d expected %0d", k, bus.out_max_exp, 100 + k - 2); end
        checks++; if (bus.out_sign !== 4'(k - 2)) begin fails++; $display("[TB] FAIL t4_sign k=%0d got %h expected %h", k, bus.out_sign, 4'(k - 2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int                   sent = 0;
    int                   got = 0;
    int                   stall_accepts = 0;
    int                   id;
    int                   pending [$];
    logic                 stalled_prev = 1'b0;
    logic [NUM_IN*MW-1:0] prev_mant = '0;
    logic [7:0]           prev_max = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      bus.out_ready = !((c <= 4) || (c >= 9 && c <= 11));
      if (sent < 10) drive(1'b1, same_set(20 + sent)); else drive(1'b0, '0);
      #1;
      if (stalled_prev) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_mant !== prev_mant || bus.out_max_exp !== prev_max)
          begin fails++; $display("[TB] FAIL t5_hold c=%0d got %h/%0d expected %h/%0d", c, bus.out_mant, bus.out_max_exp, prev_mant, prev_max); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t5_ready c=%0d got %b expected 0", c, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (pending.size() == 0) begin
          fails++; $display("[TB] FAIL t5_extra c=%0d got unexpected output %h expected none", c, bus.out_mant);
        end else begin
          id = pending.pop_front();
          if (bus.out_mant !== same_mant(id) || bus.out_max_exp !== 8'(100 + id)) begin
            fails++; $display("[TB] FAIL t5_data c=%0d got %h expected %h", c, bus.out_mant, same_mant(id));
          end
        end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        pending.push_back(20 + sent);
        sent++;
        if (c <= 4) stall_accepts++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_mant    = bus.out_mant;
      prev_max     = bus.out_max_exp;
    end
    bus.out_ready = 1'b1;
    drive(1'b0, '0);
    checks++; if (got != 10) begin fails++; $display("[TB] FAIL t5_count got %0d expected 10", got); end
    checks++; if (pending.size() != 0) begin fails++; $display("[TB] FAIL t5_leftover got %0d expected 0", pending.size()); end
    checks++; if (stall_accepts != 2) begin fails++; $display("[TB] FAIL t5_fill got %0d expected 2", stall_accepts); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, same_set(40));
    @(negedge clk);
    drive(1'b1, same_set(41));
    @(posedge clk);
    #2;
    drive(1'b0, '0);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t6_inflight got %b expected 1", bus.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t6_async got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_mant !== '0) begin fails++; $display("[TB] FAIL t6_mant got %h expected 0", bus.out_mant); end
    checks++; if (bus.out_all_zero !== 1'b1) begin fails++; $display("[TB] FAIL t6_zero got %b expected 1", bus.out_all_zero); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t6_stale k=%0d got %b expected 0", k, bus.out_valid); end
    end
    drive(1'b1, same_set(42));
    @(negedge clk);
    drive(1'b0, '0);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t6_lat1 got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t6_lat2 got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_mant !== same_mant(42)) begin fails++; $display("[TB] FAIL t6_mant_new got %h expected %h", bus.out_mant, same_mant(42)); end
    checks++; if (bus.out_max_exp !== 8'd142) begin fails++; $display("[TB] FAIL t6_max got %0d expected 142", bus.out_max_exp); end
  endtask

  initial begin
    test_reset();
    test_powers();
    test_saturate();
    test_all_zero();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
